// File: rtl/fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// fetch_decode_queue
//
// Decoupling queue between instruction fetch and decode. Each entry holds the
// fetched instruction word, its PC and the pre-generated 64-bit immediate.
// Entries leave in strict FIFO order through a valid/ready handshake, so a
// stalled decode never loses a fetched word. A synchronous flush (taken
// branch / jump) discards everything queued.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   PW     pointer width, derived from DEPTH (not overridable)
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   flush            synchronous discard of all entries (wins over push/pop)
//   in_valid         fetch presents an entry
//   in_ready         queue can accept an entry (registered state only)
//   in_instruction   fetched instruction word
//   in_pc            address of the fetched instruction
//   in_immediate     immediate from the immediate generation unit
//   out_valid        head entry available to decode
//   out_ready        decode consumes the head entry
//   out_instruction  head instruction word (NOP when empty)
//   out_pc           head PC (0 when empty)
//   out_immediate    head immediate (0 when empty)
//   count            number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_decode_queue #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instruction,
  input  logic [63:0]   in_pc,
  input  logic [63:0]   in_immediate,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instruction,
  output logic [63:0]   out_pc,
  output logic [63:0]   out_immediate,
  output logic [PW:0]   count
);

  // addi x0, x0, 0 -- what decode sees when nothing is queued.
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;
  localparam logic [PW:0] FULL_COUNT      = (PW + 1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE       = PW'(1);

  typedef struct packed {
    logic [31:0] instruction;
    logic [63:0] pc;
    logic [63:0] immediate;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q,  count_d;

  logic            push;
  logic            pop;
  entry_t          in_entry;
  entry_t          head_entry;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // in_ready is derived from count_q alone: a full queue refuses a push even in
  // a cycle where it pops, which keeps out_ready off the in_ready path.
  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);

  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  assign in_entry = '{instruction: in_instruction,
                      pc:          in_pc,
                      immediate:   in_immediate};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the if/case leaves a signal unassigned and infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the natural PW-bit overflow is the wrap.
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;   // idle, or push and pop together
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset. Stale contents are never visible
  // because the output mux masks them whenever count_q is zero, and leaving
  // the reset off lets the array map onto plain RAM/flops without reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Output mux: selected purely by registered rd_ptr_q and count_q.
  // ---------------------------------------------------------------------------
  assign head_entry = mem_q[rd_ptr_q];

  always_comb begin
    if (out_valid) begin
      out_instruction = head_entry.instruction;
      out_pc          = head_entry.pc;
      out_immediate   = head_entry.immediate;
    end else begin
      out_instruction = NOP_INSTRUCTION;
      out_pc          = '0;
      out_immediate   = '0;
    end
  end

  assign count = count_q;

endmodule
